// File: rtl/gamma_encoder.sv
// Gamma-cipher byte encryptor: ciphertext = plaintext + low byte of a 16-bit Galois LFSR,
// with a one-entry output register, valid/ready handshakes and an IDLE/RUN/DRAIN controller.
module gamma_encoder #(
  parameter logic [15:0] POLY      = 16'hB400,
  parameter logic [15:0] ZERO_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [15:0] byte_cnt_reg;
  logic [7:0]  out_data_reg;
  logic        out_valid_reg;
  logic [15:0] seed_sel;
  logic        accept;

  // Eight right-shift Galois steps per byte, unrolled into one cycle.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s_in);
    logic [15:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    end
    return s;
  endfunction

  assign lfsr_next = lfsr_adv8(lfsr_reg);
  assign seed_sel  = (seed == 16'h0000) ? ZERO_SEED : seed;
  assign in_ready  = (state_reg == RUN) & ~start & ~stop & (~out_valid_reg | out_ready);
  assign accept    = in_valid & in_ready;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign byte_cnt  = byte_cnt_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lfsr_reg      <= ZERO_SEED;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      byte_cnt_reg  <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= RUN;
            lfsr_reg     <= seed_sel;
            byte_cnt_reg <= 16'h0000;
          end
        end
        RUN: begin
          if (start) begin
            // Reseed drops whatever is still waiting in the output register.
            lfsr_reg      <= seed_sel;
            byte_cnt_reg  <= 16'h0000;
            out_valid_reg <= 1'b0;
          end else if (stop) begin
            if (out_valid_reg & ~out_ready) begin
              state_reg <= DRAIN;
            end else begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
            end
          end else if (accept) begin
            out_data_reg  <= in_data + lfsr_reg[7:0];
            out_valid_reg <= 1'b1;
            lfsr_reg      <= lfsr_next;
            byte_cnt_reg  <= byte_cnt_reg + 16'h0001;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid_reg & out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_encoder.sv
// Self-checking bench for gamma_encoder: fixed vectors, hand-written handshake corner
// cases, and a randomized 256-byte stream decoded against an independent keystream model.
module tb_gamma_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] byte_cnt;

  int total_checks = 0;
  int pass_checks  = 0;

  gamma_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [7];

  // Keystream reference: the gamma cipher's 16-bit Galois register stepped bit by bit.
  function automatic logic [15:0] ref_next(input logic [15:0] s_in);
    logic [15:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      if (s[0]) s = (s >> 1) ^ 16'hB400;
      else      s = s >> 1;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) pass_checks++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] s);
    start = 1'b1;
    seed  = s;
    tick();
    start = 1'b0;
  endtask

  logic [7:0]  pt  [256];
  logic [7:0]  gam [256];
  logic [15:0] lf;
  logic [15:0] rseed;
  logic [7:0]  od;
  logic [7:0]  exp_ct;
  logic [7:0]  dec;
  logic        fin;
  logic        fout;
  int          idx;
  int          rx;
  int          cycles;
  int          rt_bad;
  int          proto_bad;
  int          extra_rx;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = 16'h0000;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    vecs[0] = '{16'hACE1, 8'h10, 8'hF1};
    vecs[1] = '{16'h0000, 8'h20, 8'h01};
    vecs[2] = '{16'hACE1, 8'h00, 8'hE1};
    vecs[3] = '{16'h1234, 8'h01, 8'h35};
    vecs[4] = '{16'hFFFF, 8'h01, 8'h00};
    vecs[5] = '{16'h55AA, 8'h60, 8'h0A};
    vecs[6] = '{16'h00FF, 8'hFF, 8'hFE};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Single-byte vectors, each from a fresh start
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].seed);
      in_valid = 1'b1; in_data = vecs[i].din; out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d_byte_cnt", i), byte_cnt, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk($sformatf("vec%0d_busy_after_stop", i), busy, 0);
    end

    // Basic encode, back-to-back
    do_start(16'hACE1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    tick();
    chk("basic_byte0", out_data, 8'hF1);
    in_data = 8'h20;
    tick();
    chk("basic_byte1", out_data, 8'hE4);
    chk("basic_byte_cnt", byte_cnt, 2);
    in_valid = 1'b0;
    tick();
    chk("basic_out_cleared", out_valid, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Backpressure: one byte accepted, held, gamma not consumed
    do_start(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
    tick();
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data0", out_data, 8'hF1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      tick();
      chk($sformatf("bp_hold_%0d", i), out_data, 8'hF1);
    end
    chk("bp_byte_cnt", byte_cnt, 1);
    in_data = 8'h20; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready, 1);
    tick();
    chk("bp_next_gamma", out_data, 8'hE4);
    in_valid = 1'b0;
    tick();
    chk("bp_cleared", out_valid, 0);

    // Stop with pending data, start ignored in DRAIN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_out_valid", out_valid, 1);
    chk("drain_in_ready", in_ready, 0);
    start = 1'b1; seed = 16'h1234;
    tick();
    start = 1'b0;
    chk("drain_start_ignored_busy", busy, 1);
    chk("drain_start_ignored_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("drain_done_busy", busy, 0);
    chk("drain_done_valid", out_valid, 0);

    // Reseed mid-run with a pending byte
    do_start(16'h1234);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    tick();
    start = 1'b1; seed = 16'hACE1; in_data = 8'h10;
    #1;
    chk("reseed_in_ready", in_ready, 0);
    tick();
    start = 1'b0;
    chk("reseed_dropped", out_valid, 0);
    chk("reseed_cnt_zero", byte_cnt, 0);
    out_ready = 1'b1;
    tick();
    chk("reseed_gamma", out_data, 8'hF1);
    chk("reseed_cnt_one", byte_cnt, 1);
    in_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

    // Asynchronous reset mid-stream
    do_start(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_byte_cnt", byte_cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_release_in_ready", in_ready, 0);
    chk("arst_release_busy", busy, 0);

    // Randomized stream with round-trip decode
    in_valid = 1'b0;
    rseed = 16'($urandom);
    for (int k = 0; k < 256; k++) pt[k] = 8'($urandom);
    lf = (rseed == 16'h0000) ? 16'hACE1 : rseed;
    for (int k = 0; k < 256; k++) begin
      gam[k] = lf[7:0];
      lf = ref_next(lf);
    end
    tick();
    do_start(rseed);
    idx = 0; rx = 0; cycles = 0; rt_bad = 0; proto_bad = 0; extra_rx = 0;
    while ((idx < 256 || out_valid) && cycles < 5000) begin
      in_valid  = (idx < 256) && ($urandom_range(0, 3) != 0);
      in_data   = (idx < 256) ? pt[idx] : 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      fin  = in_valid & in_ready;
      fout = out_valid & out_ready;
      od   = out_data;
      if (in_ready && out_valid && !out_ready) proto_bad++;
      @(posedge clk);
      #1;
      if (fin) idx++;
      if (fout) begin
        if (rx < 256) begin
          exp_ct = pt[rx] + gam[rx];
          chk($sformatf("rand_ct_%0d", rx), od, exp_ct);
          dec = od - gam[rx];
          if (dec != pt[rx]) rt_bad++;
          rx++;
        end else begin
          extra_rx++;
        end
      end
      cycles++;
    end
    in_valid = 1'b0;
    chk("rand_timeout", (cycles < 5000) ? 1 : 0, 1);
    chk("rand_rx_count", rx, 256);
    chk("rand_extra_rx", extra_rx, 0);
    chk("rand_byte_cnt", byte_cnt, 256);
    chk("rand_round_trip", rt_bad, 0);
    chk("rand_in_ready_under_stall", proto_bad, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("rand_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
